// File: rtl/lockpick_pkg.sv
// Shared definitions for the lockpick host and game: state encoding, status codes
// and the 32-bit words that make up each status's expected result message.
package lockpick_pkg;

  localparam int KEY_BYTES = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_A,
    S_SEND_B,
    S_WAIT_OUT,
    S_RECV,
    S_REPORT
  } host_state_t;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_ERR  = 2'b01;
  localparam logic [1:0] ST_WIN  = 2'b10;
  localparam logic [1:0] ST_LOCK = 2'b11;

  localparam logic [31:0] MSG_WIN  = 32'hFACEFACE;
  localparam logic [31:0] MSG_LOCK = 32'hDEADDEAD;
  localparam logic [31:0] MSG_ERR  = 32'hBAD0BAD0;

  // A result message is this word repeated over the whole message width.
  function automatic logic [31:0] msg_word(input logic [1:0] status);
    logic [31:0] w;
    case (status)
      ST_WIN:  w = MSG_WIN;
      ST_LOCK: w = MSG_LOCK;
      ST_ERR:  w = MSG_ERR;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/lockpick_host_if.sv
// Bundle of the upstream attempt/result signals and the game pins seen by lockpick_host.
// master = the host itself; slave = the controller and game on the other side.
interface lockpick_host_if #(
  parameter int KEY_BYTES = lockpick_pkg::KEY_BYTES
);
  logic                   att_valid;
  logic                   att_ready;
  logic [KEY_BYTES*8-1:0] att_key_a;
  logic [KEY_BYTES*8-1:0] att_key_b;
  logic                   game_start;
  logic                   game_in_en;
  logic [7:0]             game_in_data;
  logic                   game_out_valid;
  logic [7:0]             game_out_data;
  logic [1:0]             game_status;
  logic                   res_valid;
  logic [1:0]             res_status;
  logic [KEY_BYTES*8-1:0] res_msg;
  logic                   res_msg_ok;
  logic                   res_timeout;
  logic                   session_open;

  modport master (
    input  att_valid, att_key_a, att_key_b, game_out_valid, game_out_data, game_status,
    output att_ready, game_start, game_in_en, game_in_data,
           res_valid, res_status, res_msg, res_msg_ok, res_timeout, session_open
  );

  modport slave (
    output att_valid, att_key_a, att_key_b, game_out_valid, game_out_data, game_status,
    input  att_ready, game_start, game_in_en, game_in_data,
           res_valid, res_status, res_msg, res_msg_ok, res_timeout, session_open
  );
endinterface

// File: rtl/lockpick_host.sv
// Initiator for lockpick_game: serialises keys A then B, collects the 32-byte reply,
// checks it against the status pattern and reports one result word. All outputs Moore.
module lockpick_host
  import lockpick_pkg::*;
#(
  parameter int KEY_BYTES = lockpick_pkg::KEY_BYTES,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  lockpick_host_if.master   bus
);

  localparam int KW = KEY_BYTES * 8;
  localparam int CW = $clog2(KEY_BYTES);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(KEY_BYTES - 1);
  localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT);

  host_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [KW-1:0] key_a_q, key_a_d;
  logic [KW-1:0] key_b_q, key_b_d;
  logic [KW-1:0] buf_q, buf_d;
  logic [1:0]    stat_q, stat_d;
  logic [1:0]    res_status_q, res_status_d;
  logic [KW-1:0] res_msg_q, res_msg_d;
  logic          res_ok_q, res_ok_d;
  logic          res_to_q, res_to_d;
  logic          sess_q, sess_d;
  logic          done, tmo;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wd_d         = wd_q;
    key_a_d      = key_a_q;
    key_b_d      = key_b_q;
    buf_d        = buf_q;
    stat_d       = stat_q;
    res_status_d = res_status_q;
    res_msg_d    = res_msg_q;
    res_ok_d     = res_ok_q;
    res_to_d     = res_to_q;
    sess_d       = sess_q;
    done         = 1'b0;
    tmo          = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.att_valid) begin
          key_a_d = bus.att_key_a;
          key_b_d = bus.att_key_b;
          cnt_d   = '0;
          buf_d   = '0;
          state_d = sess_q ? S_SEND_A : S_START;
        end
      end
      S_START: state_d = S_SEND_A;
      S_SEND_A, S_SEND_B: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BYTE) begin
          cnt_d   = '0;
          wd_d    = '0;
          state_d = (state_q == S_SEND_A) ? S_SEND_B : S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: begin
        if (bus.game_out_valid) begin
          buf_d[7:0] = bus.game_out_data;
          stat_d     = bus.game_status;
          cnt_d      = CW'(1);
          wd_d       = '0;
          state_d    = S_RECV;
        end else if (wd_q == WD_LIMIT) begin
          tmo = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_RECV: begin
        if (bus.game_out_valid) begin
          buf_d[{cnt_q, 3'b000} +: 8] = bus.game_out_data;
          cnt_d = cnt_q + CW'(1);
          wd_d  = '0;
          done  = (cnt_q == LAST_BYTE);
        end else if (wd_q == WD_LIMIT) begin
          tmo = 1'b1;
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end
      S_REPORT: begin
        // A timeout reports status 00, so only a genuine error reply keeps the session.
        sess_d  = (res_status_q == ST_ERR);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Result fields are loaded on the edge into REPORT so they are valid with res_valid.
    if (done) begin
      state_d      = S_REPORT;
      res_status_d = stat_d;
      res_msg_d    = buf_d;
      res_ok_d     = (stat_d != ST_NONE) && (buf_d == {(KEY_BYTES / 4){msg_word(stat_d)}});
      res_to_d     = 1'b0;
    end else if (tmo) begin
      state_d      = S_REPORT;
      res_status_d = ST_NONE;
      res_msg_d    = buf_q;
      res_ok_d     = 1'b0;
      res_to_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wd_q         <= '0;
      key_a_q      <= '0;
      key_b_q      <= '0;
      buf_q        <= '0;
      stat_q       <= ST_NONE;
      res_status_q <= ST_NONE;
      res_msg_q    <= '0;
      res_ok_q     <= 1'b0;
      res_to_q     <= 1'b0;
      sess_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wd_q         <= wd_d;
      key_a_q      <= key_a_d;
      key_b_q      <= key_b_d;
      buf_q        <= buf_d;
      stat_q       <= stat_d;
      res_status_q <= res_status_d;
      res_msg_q    <= res_msg_d;
      res_ok_q     <= res_ok_d;
      res_to_q     <= res_to_d;
      sess_q       <= sess_d;
    end
  end

  logic send_a, send_b;
  assign send_a = (state_q == S_SEND_A);
  assign send_b = (state_q == S_SEND_B);

  assign bus.att_ready    = (state_q == S_IDLE);
  assign bus.game_start   = (state_q == S_START);
  assign bus.game_in_en   = send_a | send_b;
  assign bus.game_in_data = send_a ? key_a_q[{cnt_q, 3'b000} +: 8] :
                            send_b ? key_b_q[{cnt_q, 3'b000} +: 8] : 8'h00;
  assign bus.res_valid    = (state_q == S_REPORT);
  assign bus.res_status   = res_status_q;
  assign bus.res_msg      = res_msg_q;
  assign bus.res_msg_ok   = res_ok_q;
  assign bus.res_timeout  = res_to_q;
  assign bus.session_open = sess_q;

endmodule
